// File: rtl/jacobi_input_loader_pkg.sv
// -----------------------------------------------------------------------------
// jacobi_input_loader_pkg
// Common constants for the Jacobi eigenvalue engine plus the loader FSM state
// encoding. The core and the testbench can decode the loader state with it.
// -----------------------------------------------------------------------------
package jacobi_input_loader_pkg;

    localparam int unsigned JACOBI_N                  = 8;
    localparam int unsigned JACOBI_INPUT_WORD_WIDTH   = 16;  // Q(1.0.15)
    localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH  = 20;  // Q(1.4.15)
    localparam int unsigned JACOBI_N_INPUT_DATA       = 36;  // N*(N+1)/2
    localparam int unsigned JACOBI_ADDR_WIDTH         = 7;
    localparam int unsigned JACOBI_LOG2_N             = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MIRROR = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/jacobi_input_loader_tri_index_counter.sv
// -----------------------------------------------------------------------------
// tri_index_counter
// Walks the (row, col) indices of the upper triangle of an N x N matrix in
// row-major order: (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   inc_i          advance to the next upper-triangle element
//   clear_i        return to (0,0); has priority over inc_i
//   row_o, col_o   current element indices
//   last_o         current element is (N-1,N-1)
//   diag_o         current element is on the diagonal
//   first_o        current element is (0,0)
// -----------------------------------------------------------------------------
module tri_index_counter
    import jacobi_input_loader_pkg::*;
#(
    parameter int unsigned N     = JACOBI_N,
    parameter int unsigned IDX_W = JACOBI_LOG2_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o,
    output logic             diag_o,
    output logic             first_o
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == IDX_W'(N - 1)) begin
                // End of row: next row starts on its diagonal element.
                row_d = row_q + IDX_W'(1);
                col_d = row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign last_o  = (row_q == IDX_W'(N - 1)) && (col_q == IDX_W'(N - 1));
    assign diag_o  = (row_q == col_q);
    assign first_o = (row_q == '0) && (col_q == '0);

endmodule

// File: rtl/jacobi_input_loader.sv
// -----------------------------------------------------------------------------
// jacobi_input_loader
// Accepts the upper triangle of a symmetric N x N matrix as a stream of signed
// Q(1.0.15) words, sign-extends each to Q(1.4.15) and writes it to the matrix
// memory at (i,j) and, for off-diagonal words, at the mirror (j,i). Pulses
// load_done once the whole matrix has been written.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   s_tdata        input word, signed Q(1.0.15)
//   s_tvalid       input word valid
//   s_tready       loader accepts a word (decoded from state only)
//   s_tlast        marks the final word of the matrix (checked, not obeyed)
//   core_busy      Jacobi core running; a new load waits while high
//   mem_we         registered memory write enable
//   mem_addr       registered write address, row*N+col
//   mem_wdata      registered write data, Q(1.4.15)
//   load_done      one-cycle pulse after the final write
//   err_tlast      sticky tlast position mismatch for the current frame
// -----------------------------------------------------------------------------
module jacobi_input_loader
    import jacobi_input_loader_pkg::*;
#(
    parameter int unsigned N      = JACOBI_N,
    parameter int unsigned IN_W   = JACOBI_INPUT_WORD_WIDTH,
    parameter int unsigned OUT_W  = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int unsigned ADDR_W = JACOBI_ADDR_WIDTH,
    parameter int unsigned IDX_W  = JACOBI_LOG2_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic              core_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [OUT_W-1:0]  mem_wdata,
    output logic              load_done,
    output logic              err_tlast
);

    loader_state_t     state_q, state_d;
    logic [OUT_W-1:0]  held_q, held_d;
    logic [ADDR_W-1:0] mir_addr_q, mir_addr_d;
    logic              held_last_q, held_last_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [OUT_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              load_done_q, load_done_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  row, col;
    logic              idx_last, idx_diag, idx_first;
    logic              hs;
    logic [OUT_W-1:0]  ext_word;
    logic [ADDR_W-1:0] addr_ij, addr_ji;

    assign s_tready = (state_q == LOAD);
    assign hs       = s_tvalid && (state_q == LOAD);

    // Pure sign extension: integer bits copy the sign, fraction untouched.
    assign ext_word = {{(OUT_W - IN_W){s_tdata[IN_W-1]}}, s_tdata};
    assign addr_ij  = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    assign addr_ji  = ADDR_W'(col) * ADDR_W'(N) + ADDR_W'(row);

    tri_index_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (hs),
        .clear_i (state_q == DONE),
        .row_o   (row),
        .col_o   (col),
        .last_o  (idx_last),
        .diag_o  (idx_diag),
        .first_o (idx_first)
    );

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        mir_addr_d  = mir_addr_q;
        held_last_d = held_last_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (!core_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (s_tvalid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_ij;
                    mem_wdata_d = ext_word;
                    held_d      = ext_word;
                    mir_addr_d  = addr_ji;
                    held_last_d = idx_last;
                    // First word of a frame drops the previous frame's error.
                    err_d = (idx_first ? 1'b0 : err_q) | (s_tlast != idx_last);
                    if (!idx_diag) begin
                        state_d = MIRROR;
                    end else if (idx_last) begin
                        state_d = DONE;
                    end
                end
            end
            MIRROR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = mir_addr_q;
                mem_wdata_d = held_q;
                state_d     = held_last_q ? DONE : LOAD;
            end
            DONE: begin
                load_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            held_q      <= '0;
            mir_addr_q  <= '0;
            held_last_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            mir_addr_q  <= mir_addr_d;
            held_last_q <= held_last_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = load_done_q;
    assign err_tlast = err_q;

endmodule

// File: doc/jacobi_input_loader.md
# jacobi_input_loader

Front-end stage of the Jacobi eigenvalue engine. It accepts the upper triangle of a symmetric JACOBI_N×JACOBI_N matrix as a stream of JACOBI_N_INPUT_DATA Q(1.0.15) words. Each word is sign-extended to Q(1.4.15) and written into the engine's matrix memory at both (i,j) and its mirror (j,i). When the full matrix is in memory, the block pulses `load_done` to start the rotation core.

## Interface
Parameters:
- N, JACOBI_N (8), matrix dimension
- IN_W, JACOBI_INPUT_WORD_WIDTH (16), input word width, Q(1.0.15)
- OUT_W, JACOBI_OUTPUT_WORD_WIDTH (20), memory word width, Q(1.4.15)
- N_IN, JACOBI_N_INPUT_DATA (36), words per matrix, N*(N+1)/2
- ADDR_W, JACOBI_ADDR_WIDTH (7), memory address width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_tdata  in  IN_W  input word, signed
- s_tvalid  in  1  input word valid
- s_tready  out  1  loader can accept a word
- s_tlast  in  1  marks the last word of the matrix
- core_busy  in  1  Jacobi core is running; blocks a new load
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  write address, row*N+col
- mem_wdata  out  OUT_W  write data, Q(1.4.15)
- load_done  out  1  one-cycle pulse: matrix complete
- err_tlast  out  1  sticky tlast mismatch flag for the current frame

## Operation
- Input order is row-major upper triangle: (0,0),(0,1)…(0,7),(1,1)…(1,7),…,(7,7).
- Row counter i and column counter j both reset to 0. After each accepted word:
  - if j==N-1, then i←i+1 and j←i+1 (the new diagonal);
  - otherwise j←j+1.
- Conversion: mem_wdata = {4{s_tdata[15]}, s_tdata}. This is pure sign extension; the fractional bits are unchanged and no rounding occurs.
- FSM states:
  - IDLE: s_tready=0. Go to LOAD when core_busy==0.
  - LOAD: s_tready=1. On a handshake, write (i,j).
    - If i≠j, go to MIRROR.
    - Else, if this was word N_IN-1, go to DONE.
    - Otherwise stay in LOAD.
  - MIRROR: s_tready=0. Write the held word to address j*N+i. Go to DONE if the held word was the last word, otherwise go to LOAD.
  - DONE: pulse load_done, clear the counters, go to IDLE.
- s_tready is decoded from the state register only; it has no combinational path from s_tvalid.
- tlast handling:
  - err_tlast is set if s_tlast=1 on any word other than word N_IN-1, or if s_tlast=0 on word N_IN-1.
  - err_tlast clears on the first handshake of the next frame.
  - The frame length is always N_IN words; tlast never truncates or extends a frame.
- core_busy is sampled only in IDLE. It is ignored once LOAD has been entered.

## Timing
- Reset values: s_tready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, err_tlast=0. FSM resets to IDLE, counters to 0.
- mem_we, mem_addr and mem_wdata are registered. A handshake at edge k produces a write visible in cycle k+1.
- For an off-diagonal word, the mirror write follows in cycle k+2, and s_tready is low during cycle k+1.
- mem_we is high only for cycles carrying a write.
- A full matrix makes 64 writes. With s_tvalid held high, the frame takes 64 cycles in LOAD/MIRROR.
- load_done is high for exactly one cycle, the cycle after the cycle carrying the final write. The final write is (7,7).
- s_tready rises at the earliest one cycle after load_done, and only if core_busy==0.
- A gap in s_tvalid during LOAD stalls without losing state.
- Reset asserted mid-frame discards the partial matrix immediately. Memory contents are left as they are, and the next frame restarts at (0,0).

## Structure
- The following constants, already in the common package, are used directly and never redefined: JACOBI_N, JACOBI_INPUT_WORD_WIDTH, JACOBI_OUTPUT_WORD_WIDTH, JACOBI_N_INPUT_DATA, JACOBI_ADDR_WIDTH, JACOBI_LOG2_N.
- Add a `loader_state_t` enum (IDLE, LOAD, MIRROR, DONE) to the common package so the core and testbench can decode it.
- Natural sub-module: `tri_index_counter`. It holds the (i,j) upper-triangle walker with inc/clear inputs and last-element and diagonal flags.

## Test plan
- Identity frame: diagonal words 0x7FFF, all others 0, s_tvalid held high.
  - Response: exactly 64 writes; addr 0,9,…,63 get 0x07FFF; all other addresses get 0.
  - load_done appears once, 1 cycle after the final write.
- Negative value and mirroring: word (0,1)=0x8000.
  - Response: addr 1 and addr 8 both get 0xF8000, in consecutive cycles; s_tready is low for 1 cycle between the two writes.
- Backpressure: core_busy=1 at the start.
  - Response: s_tready stays 0 until core_busy falls, then rises 1 cycle later.
  - Mid-frame, a core_busy rise is ignored and the load completes.
- Bubbles: random s_tvalid with 50% duty.
  - Response: memory image identical to the gap-free run; 64 writes total.
- tlast errors:
  - s_tlast on word 10 sets err_tlast; the frame still consumes 36 words and pulses load_done.
  - On the next correct frame, err_tlast clears at that frame's first handshake.
- Reset mid-frame: assert rst_n=0 after 20 words.
  - Response: all outputs return to their reset values asynchronously.
  - The next 36-word frame writes starting at addr 0 and completes normally.
